// File: rtl/seg_scan4.sv
// -----------------------------------------------------------------------------
// seg_scan4 -- four-digit multiplexed seven-segment scanner (MM:SS display)
//
// Purpose:
//    Time-multiplexes four packed BCD digits onto one shared, active-low
//    segment bus. The BCD input is copied into a shadow register once per
//    frame (on the digit-3 -> digit-0 wrap), so a counter rollover part way
//    through a frame can never produce a torn display.
//
// Parameters:
//    DIV     clock cycles per digit slot (>= 2)
//
// Ports:
//    clk     in   system clock, rising edge
//    rst     in   asynchronous reset, active low
//    en      in   scan enable; low blanks the display and freezes the scan
//    bcd     in   [15:0] {min_tens, min_ones, sec_tens, sec_ones}
//    colon   in   lights the decimal point of digit 2 (minute-ones)
//    an      out  [3:0] digit anodes, active low, bit 0 = rightmost digit
//    seg     out  [6:0] segments {g,f,e,d,c,b,a}, active low
//    dp      out  decimal point, active low
//    frame   out  one-cycle pulse marking a new snapshot
//
// Build option:
//    SEG_SCAN_LZB_EN  when defined, the digit-3 slot is blanked whenever the
//                     minute-tens digit of the snapshot is zero (leading-zero
//                     blanking). Slot timing and frame are unaffected.
// -----------------------------------------------------------------------------
module seg_scan4 #(
   parameter int DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] bcd,
   input  logic        colon,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int            DW       = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   // Scan state
   logic [DW-1:0] div_q,    div_d;
   logic [1:0]    idx_q,    idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic          shcol_q,  shcol_d;

   // Output registers
   logic [3:0]    an_q,     an_d;
   logic [6:0]    seg_q,    seg_d;
   logic          dp_q,     dp_d;
   logic          frame_q,  frame_d;

   logic          tick;
   logic          wrap;
   logic          blank3;
   logic [3:0]    cur_digit;

   // BCD to active-low {g..a}; non-decimal codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      tick      = en && (div_q == DIV_LAST);
      wrap      = tick && (idx_q == 2'd3);
      cur_digit = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
      blank3    = (idx_q == 2'd3) && (shadow_q[15:12] == 4'd0);
`else
      blank3    = 1'b0;
`endif

      // Slot counter and digit index only advance while enabled.
      div_d    = div_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      shcol_d  = shcol_q;
      if (en) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end
      if (tick) begin
         idx_d = idx_q + 2'd1;
      end
      // Snapshot on the 3 -> 0 wrap so the whole next frame is consistent.
      if (wrap) begin
         shadow_d = bcd;
         shcol_d  = colon;
      end

      // Outputs are driven from the pre-edge index, so they lag idx by one
      // cycle; an and seg change together, so no inter-slot ghosting.
      if (en && !blank3) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = decode(cur_digit);
      end else begin
         an_d  = 4'b1111;
         seg_d = 7'b1111111;
      end
      dp_d    = ~(en && shcol_q && (idx_q == 2'd2));
      frame_d = wrap;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q    <= '0;
         idx_q    <= 2'd0;
         shadow_q <= 16'h0000;
         shcol_q  <= 1'b0;
         an_q     <= 4'b1111;
         seg_q    <= 7'b1111111;
         dp_q     <= 1'b1;
         frame_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         shcol_q  <= shcol_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         frame_q  <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan4.sv
// -----------------------------------------------------------------------------
// tb_seg_scan4 -- self-checking bench for seg_scan4 (DIV = 4)
//
// Each clock, the expected outputs for the coming edge are computed from a
// behavioural model of the scanner and pushed to a queue; after the edge they
// are popped and compared with the DUT. Directed checks on top of that pin
// down the literal values from the scanner's documented behaviour.
// Honours SEG_SCAN_LZB_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_seg_scan4;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] bcd;
   logic        colon;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   seg_scan4 #(.DIV(DIV)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .bcd   (bcd),
      .colon (colon),
      .an    (an),
      .seg   (seg),
      .dp    (dp),
      .frame (frame)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } out_t;

   out_t        sb_q[$];
   out_t        obs;
   int          tests_run    = 0;
   int          tests_failed = 0;

   // Reference model state
   int          m_div;
   int          m_idx;
   logic [15:0] m_shadow;
   logic        m_shcol;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // One clock: predict, advance model, let the edge happen, compare.
   task automatic cycle();
      out_t e;
      logic lzb;
      lzb = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      lzb = (m_idx == 3) && (m_shadow[15:12] == 4'd0);
`endif
      if (en && !lzb) begin
         e.an  = ~(4'b0001 << m_idx);
         e.seg = ref_seg(m_shadow[m_idx*4 +: 4]);
      end else begin
         e.an  = 4'b1111;
         e.seg = 7'b1111111;
      end
      e.dp    = !(en && m_shcol && (m_idx == 2));
      e.frame = en && (m_div == DIV - 1) && (m_idx == 3);
      sb_q.push_back(e);

      if (en) begin
         if (m_div == DIV - 1) begin
            m_div = 0;
            if (m_idx == 3) begin
               m_shadow = bcd;
               m_shcol  = colon;
            end
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_div++;
         end
      end

      @(posedge clk);
      #1;
      obs = {an, seg, dp, frame};
      $display("[TB] t=%0t en=%b bcd=%h an=%b seg=%b dp=%b frame=%b",
               $time, en, bcd, an, seg, dp, frame);
      check_eq("sb_size", 16'(sb_q.size()), 16'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_eq("sb_out", 16'(obs), 16'(e));
      end
   endtask

   // Run until a frame pulse is observed, bounded by max_cycles.
   task automatic wait_frame(input int max_cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         cycle();
         seen = obs.frame;
      end
      check_eq("frame_seen", {15'b0, seen}, 16'd1);
   endtask

   // Asynchronous reset, checked between clock edges.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_eq("rst_an",    {12'b0, an},    16'h000F);
      check_eq("rst_seg",   {9'b0, seg},    16'h007F);
      check_eq("rst_dp",    {15'b0, dp},    16'h0001);
      check_eq("rst_frame", {15'b0, frame}, 16'h0000);
      m_div    = 0;
      m_idx    = 0;
      m_shadow = 16'h0000;
      m_shcol  = 1'b0;
      sb_q.delete();
      #2;
      rst = 1'b1;
   endtask

   logic [3:0] seq_an  [4];
   logic [6:0] seq_seg [4];
   logic [3:0] an3_exp;
   logic [6:0] seg3_exp;

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      bcd   = 16'h0000;
      colon = 1'b0;
      seq_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seq_seg = '{7'b0110000, 7'b0100100, 7'b0010000, 7'b0010010};

      #3;
      do_reset();

      // First enabled edge shows digit 0 of the cleared shadow.
      en  = 1'b1;
      bcd = 16'h5923;
      cycle();
      check_eq("first_an",  {12'b0, obs.an}, 16'h000E);
      check_eq("first_seg", {9'b0, obs.seg}, 16'h0040);

      // Scan sequence for 5923.
      wait_frame(40);
      for (int k = 0; k < 16; k++) begin
         cycle();
         check_eq("seq_an",    {12'b0, obs.an},    {12'b0, seq_an[k/4]});
         check_eq("seq_seg",   {9'b0, obs.seg},    {9'b0, seq_seg[k/4]});
         check_eq("seq_frame", {15'b0, obs.frame}, {15'b0, (k == 15)});
      end

      // Tear-free update: change bcd during the digit-1 slot.
      bcd = 16'h0959;
      wait_frame(40);
`ifdef SEG_SCAN_LZB_EN
      an3_exp  = 4'b1111;
      seg3_exp = 7'b1111111;
`else
      an3_exp  = 4'b0111;
      seg3_exp = 7'b1000000;
`endif
      for (int j = 1; j <= 16; j++) begin
         cycle();
         if (j == 5) bcd = 16'h1000;
         if (j >= 9 && j <= 12)
            check_eq("tear_d2_seg", {9'b0, obs.seg}, 16'h0010);
         if (j >= 13) begin
            check_eq("tear_d3_an",  {12'b0, obs.an}, {12'b0, an3_exp});
            check_eq("tear_d3_seg", {9'b0, obs.seg}, {9'b0, seg3_exp});
         end
      end
      check_eq("tear_frame", {15'b0, obs.frame}, 16'h0001);
      for (int j = 1; j <= 16; j++) begin
         cycle();
         if (j <= 4)
            check_eq("new_d0_seg", {9'b0, obs.seg}, 16'h0040);
         if (j >= 13) begin
            check_eq("new_d3_an",  {12'b0, obs.an}, 16'h0007);
            check_eq("new_d3_seg", {9'b0, obs.seg}, 16'h0079);
         end
      end

      // Invalid digit plus colon.
      bcd   = 16'h0A00;
      colon = 1'b1;
      wait_frame(40);
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (k / 4 == 2) begin
            check_eq("col_seg", {9'b0, obs.seg}, 16'h003F);
            check_eq("col_dp",  {15'b0, obs.dp}, 16'h0000);
         end else begin
            check_eq("col_dp",  {15'b0, obs.dp}, 16'h0001);
         end
      end

      // Enable gating during the digit-2 slot at div = 1.
      bcd   = 16'h1A00;
      colon = 1'b0;
      wait_frame(40);
      for (int j = 1; j <= 9; j++) cycle();
      en = 1'b0;
      for (int j = 0; j < 10; j++) begin
         cycle();
         check_eq("dis_an",    {12'b0, obs.an},    16'h000F);
         check_eq("dis_frame", {15'b0, obs.frame}, 16'h0000);
      end
      en = 1'b1;
      for (int j = 0; j < 3; j++) begin
         cycle();
         check_eq("resume_d2_an", {12'b0, obs.an}, 16'h000B);
      end
      cycle();
      check_eq("resume_d3_an", {12'b0, obs.an}, 16'h0007);

      // Leading-zero digit 3.
      bcd = 16'h0905;
      wait_frame(40);
`ifdef SEG_SCAN_LZB_EN
      an3_exp  = 4'b1111;
      seg3_exp = 7'b1111111;
`else
      an3_exp  = 4'b0111;
      seg3_exp = 7'b1000000;
`endif
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (k >= 12) begin
            check_eq("lzb_an",  {12'b0, obs.an}, {12'b0, an3_exp});
            check_eq("lzb_seg", {9'b0, obs.seg}, {9'b0, seg3_exp});
         end
      end

      // Asynchronous reset in the middle of a slot.
      for (int j = 0; j < 6; j++) cycle();
      do_reset();
      cycle();
      check_eq("post_rst_an",  {12'b0, obs.an}, 16'h000E);
      check_eq("post_rst_seg", {9'b0, obs.seg}, 16'h0040);
      for (int j = 0; j < 8; j++) cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seg_scan4.md
# seg_scan4

Four-digit multiplexed seven-segment scanner for the minutes:seconds display. It sits directly downstream of the mod-60 BCD counters and takes their packed BCD outputs as its `bcd` input. It time-multiplexes the four digits onto one shared segment bus. It also snapshots the input once per frame so that a counter rollover never tears a displayed frame.

## Interface
- `DIV`, default 50000: clock cycles per digit slot, minimum 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; low blanks the display and freezes the scan.
- `bcd`  in  16  packed digits `{min_tens, min_ones, sec_tens, sec_ones}`, i.e. `{count60_min, count60_sec}`.
- `colon`  in  1  lights the decimal point of digit 2 (minute-ones) when high.
- `an`  out  4  digit anodes, active low; bit k selects digit k, digit 0 is rightmost.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active low.
- `dp`  out  1  decimal point, active low.
- `frame`  out  1  one-cycle pulse marking a new snapshot.

## Operation
- Internal state:
  - `div`: 0..DIV-1.
  - `idx`: 2-bit digit index.
  - `shadow`: 16-bit copy of `bcd`.
  - `shcol`: 1-bit copy of `colon`.
- `tick` = `en && div == DIV-1`.
- Every edge with `en`=1:
  - `div` increments and wraps to 0 on `tick`.
  - On `tick`, `idx` increments modulo 4.
  - On `tick` with `idx`==3, load `shadow`<=`bcd` and `shcol`<=`colon`, and set `frame`<=1; otherwise `frame`<=0.
- Output registers, every edge with `en`=1:
  - `an` <= ~(1<<`idx`).
  - `seg` <= decode(`shadow[4*idx+3:4*idx]`).
  - `dp` <= ~(`shcol` && `idx`==2).
- Decode table (`{g..a}`, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 4'hA..4'hF = 0111111 (dash, g only).
- `en`=0:
  - `div`, `idx`, `shadow` and `shcol` hold.
  - Next edge: `an`=1111, `seg`=1111111, `dp`=1, `frame`=0.
  - When `en` returns high, the scan resumes at the held `idx` and `div`.
- Reset (asynchronous, any time, including mid-slot): `div`=0, `idx`=0, `shadow`=0, `shcol`=0, `an`=1111, `seg`=1111111, `dp`=1, `frame`=0.

## Timing
- Outputs lag `idx` by exactly one cycle. The first edge after reset release with `en`=1 shows digit 0 of `shadow`=0.
- Each digit is displayed for exactly DIV cycles. A frame is 4·DIV cycles.
- `frame` is high for the single cycle following the 3→0 `idx` edge, once every 4·DIV enabled cycles.
- Snapshot latency: a `bcd` change is displayed from the first digit-0 slot after the next 3→0 wrap. This is at most 4·DIV+1 cycles after the change.
- A `bcd` change coincident with the snapshot edge is captured, because the snapshot samples `bcd` at that edge.
- Changes to `bcd` or `colon` mid-frame never alter the current frame.
- Only one anode is ever low. No glitch is produced between slots because `an` and `seg` update on the same edge.

## Configuration
- `SEG_SCAN_LZB_EN` enables leading-zero blanking. When defined and `shadow[15:12]`==0, the digit-3 slot drives `an`=1111 and `seg`=1111111. Timing and `frame` are unchanged.
- When the macro is undefined, digit 3 always displays its decoded value, including "0".

## Test plan
- Reset: hold `rst`=0 mid-scan → `an`=1111, `seg`=1111111, `dp`=1, `frame`=0, asynchronously and without waiting for a clock edge.
- DIV=4, `bcd`=16'h5923, `en`=1, after the first `frame` → repeating `an`/`seg` sequence, each for 4 cycles, with `frame` every 16 cycles:
  - 1110/0110000
  - 1101/0100100
  - 1011/0010000
  - 0111/0010010
- Tear-free update: change `bcd` 16'h0959→16'h1000 during digit-1 slot → rest of frame still shows 0959; next frame shows 1000.
- Invalid and colon: `bcd`=16'h0A00, `colon`=1 → digit-2 slot shows `seg`=0111111 with `dp`=0; the other slots show `dp`=1.
- Enable gating: drop `en` for 10 cycles during digit-2 slot at `div`=1 → `an`=1111 from next edge; on re-enable, digit 2 is shown for the remaining 3 cycles before digit 3.
- `bcd`=16'h0905:
  - With `SEG_SCAN_LZB_EN` defined: digit-3 slot gives `an`=1111.
  - Without the macro: digit-3 slot gives `an`=0111, `seg`=1000000.
